// File: rtl/mul_rep_add_ctrl.sv
// Control FSM for the 16-bit repeated-addition multiplier: sequences operand loads,
// add/decrement iterations until B is zero, with abort and an iteration watchdog.
module mul_rep_add_ctrl #(
    parameter int unsigned          CNT_W    = 16,
    parameter logic [CNT_W-1:0]     MAX_ITER = CNT_W'(16'hFFFF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             eqz,
    output logic             lda,
    output logic             ldb,
    output logic             clrp,
    output logic             ldp,
    output logic             decb,
    output logic             op_sel,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] iter_cnt
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        RUN    = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        lda       = 1'b0;
        ldb       = 1'b0;
        clrp      = 1'b0;
        ldp       = 1'b0;
        decb      = 1'b0;
        op_sel    = 1'b0;
        done      = 1'b0;
        busy      = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (start) state_d = LOAD_A;
            end
            LOAD_A: begin
                lda       = 1'b1;
                cnt_d     = '0;
                timeout_d = 1'b0;
                state_d   = LOAD_B;
            end
            LOAD_B: begin
                ldb     = 1'b1;
                clrp    = 1'b1;
                op_sel  = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                op_sel = 1'b1;
                // B reaching zero wins over the watchdog when both happen together.
                if (eqz) begin
                    timeout_d = 1'b0;
                    state_d   = DONE;
                end else if (cnt_q < MAX_ITER) begin
                    ldp   = 1'b1;
                    decb  = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Abort gates the strobes combinationally in the same cycle it is seen.
        if (abort && (state_q != IDLE)) begin
            state_d   = IDLE;
            cnt_d     = cnt_q;
            timeout_d = timeout_q;
            lda       = 1'b0;
            ldb       = 1'b0;
            clrp      = 1'b0;
            ldp       = 1'b0;
            decb      = 1'b0;
            done      = 1'b0;
        end
    end

    assign timeout  = timeout_q;
    assign iter_cnt = cnt_q;

endmodule

// File: tb/tb_mul_rep_add_ctrl.sv
// Bench for mul_rep_add_ctrl: behavioural datapath around the controller, per-cycle
// strobe checks and a result scoreboard popped on each done pulse.
module tb_mul_rep_add_ctrl;

    localparam int unsigned CNT_W = 16;
    localparam int          MAXI  = 4;
    localparam int          W     = 16 + CNT_W + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             eqz;
    logic             lda, ldb, clrp, ldp, decb, op_sel, busy, done, timeout;
    logic [CNT_W-1:0] iter_cnt;

    logic [15:0] a_val = '0, b_val = '0;
    logic [15:0] data_in;
    logic [15:0] a_q, b_q, p_q;

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    mul_rep_add_ctrl #(.CNT_W(CNT_W), .MAX_ITER(CNT_W'(MAXI))) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .eqz(eqz),
        .lda(lda), .ldb(ldb), .clrp(clrp), .ldp(ldp), .decb(decb),
        .op_sel(op_sel), .busy(busy), .done(done), .timeout(timeout),
        .iter_cnt(iter_cnt)
    );

    always #5 clk = ~clk;

    // Datapath model: A, B, P registers and the B==0 comparator.
    assign data_in = op_sel ? b_val : a_val;
    assign eqz     = (b_q == 16'd0);

    always @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            p_q <= '0;
        end else begin
            if (lda)  a_q <= data_in;
            if (ldb)  b_q <= data_in;
            if (decb) b_q <= b_q - 16'd1;
            if (clrp) p_q <= '0;
            if (ldp)  p_q <= p_q + a_q;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_exp(input int a, input int b);
        int n;
        logic [15:0] p;
        n = (b > MAXI) ? MAXI : b;
        p = 16'(a * n);
        exp_q.push_back({(b > MAXI) ? 1'b1 : 1'b0, CNT_W'(n), p});
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("result_p", p_q, e[15:0]);
                check("result_iter", iter_cnt, e[16 +: CNT_W]);
                check("result_timeout", timeout, e[W-1]);
            end
        end
    end

    task automatic idle_checks();
        check("idle_strobes", {lda, ldb, clrp, ldp, decb}, 5'b0);
        check("idle_busy_done", {busy, done}, 2'b0);
        check("idle_op_sel", op_sel, 0);
    endtask

    // Called at a negedge; start is sampled at the next posedge (cycle 0).
    task automatic run_op(input int a, input int b, input bit pulse_busy, input bit hold);
        int n, total;
        n = (b > MAXI) ? MAXI : b;
        total = 4 + n;
        a_val = 16'(a);
        b_val = 16'(b);
        push_exp(a, b);
        start = 1'b1;
        for (int k = 1; k <= total + 1; k++) begin
            @(negedge clk);
            check("lda", lda, k == 1);
            check("ldb", ldb, k == 2);
            check("clrp", clrp, k == 2);
            check("ldp", ldp, (k >= 3) && (k < 3 + n));
            check("decb", decb, (k >= 3) && (k < 3 + n));
            check("busy", busy, k <= total);
            check("done", done, k == total);
            if (k == 1) check("op_sel_a", op_sel, 0);
            if (k >= 2 && k < total) check("op_sel_b", op_sel, 1);
            start = hold ? 1'b1 : (pulse_busy && k == 3);
        end
        if (hold) begin
            push_exp(a, b);
            @(negedge clk);
            check("held_start_lda", lda, 1);
            start = 1'b0;
            repeat (total + 1) @(negedge clk);
        end
        check("end_idle_busy", busy, 0);
    endtask

    initial begin
        // Reset and idle.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            idle_checks();
            check("idle_iter", iter_cnt, 0);
            check("idle_timeout", timeout, 0);
        end

        run_op(7, 3, 0, 0);
        run_op(9, 0, 0, 0);
        run_op(2, 10, 0, 0);

        // Abort in the second RUN cycle.
        a_val = 16'd5;
        b_val = 16'd6;
        start = 1'b1;
        repeat (3) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(negedge clk);
        check("abort_pre_ldp", ldp, 1);
        abort = 1'b1;
        #1;
        check("abort_ldp", ldp, 0);
        check("abort_decb", decb, 0);
        check("abort_done", done, 0);
        @(negedge clk);
        abort = 1'b0;
        idle_checks();
        check("abort_p", p_q, 16'd5);
        check("abort_iter", iter_cnt, 1);
        check("abort_timeout", timeout, 0);
        repeat (3) @(negedge clk);
        run_op(4, 2, 0, 0);

        // Reset in the middle of RUN.
        a_val = 16'd3;
        b_val = 16'd5;
        start = 1'b1;
        repeat (4) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("pre_rst_ldp", ldp, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle_checks();
        check("rst_iter", iter_cnt, 0);
        check("rst_timeout", timeout, 0);
        @(negedge clk);

        run_op(4, 2, 1, 0);
        run_op(3, 2, 0, 1);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
